// File: rtl/mips_datapath_pc_predict.sv
// Branch resolve-and-predict unit for the pipelined MIPS PC path.
// Evaluates the full MIPS compare set. A pattern history table of
// saturating counters predicts at fetch and is trained at execute.
// Registers the resolved action and the mispredict pulse, and keeps
// saturating branch and mispredict statistics.
module mips_datapath_pc_predict #(
    parameter int INDEX_BITS   = 6,
    parameter int COUNTER_BITS = 2,
    parameter int PC_BITS      = 32,
    parameter int STAT_BITS    = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [PC_BITS-1:0]   lookupPc,
    output logic                 lookupTaken,
    input  logic                 resolveValid,
    input  logic [PC_BITS-1:0]   resolvePc,
    input  logic [1:0]           actionIn,
    input  logic [2:0]           condition,
    input  logic                 statusZero,
    input  logic                 statusNegative,
    input  logic                 predictedTaken,
    output logic [1:0]           actionOut,
    output logic                 mispredict,
    output logic [STAT_BITS-1:0] branchCount,
    output logic [STAT_BITS-1:0] missCount
);

    localparam int DEPTH = 1 << INDEX_BITS;

    // Weakly not-taken: the value just below the taken threshold.
    localparam logic [COUNTER_BITS-1:0] CNT_INIT = COUNTER_BITS'((1 << (COUNTER_BITS - 1)) - 1);
    localparam logic [COUNTER_BITS-1:0] CNT_MAX  = '1;
    localparam logic [STAT_BITS-1:0]    STAT_MAX = '1;

    typedef enum logic [1:0] {
        ACT_INC     = 2'd0,
        ACT_BRANCH  = 2'd1,
        ACT_JUMP    = 2'd2,
        ACT_JUMPREG = 2'd3
    } action_e;

    typedef enum logic [2:0] {
        COND_NONE = 3'd0,
        COND_EQ   = 3'd1,
        COND_NE   = 3'd2,
        COND_LTZ  = 3'd3,
        COND_GEZ  = 3'd4,
        COND_LEZ  = 3'd5,
        COND_GTZ  = 3'd6,
        COND_RSVD = 3'd7
    } cond_e;

    // Saturating up/down step of a prediction counter.
    function automatic logic [COUNTER_BITS-1:0] ctr_step(
        input logic [COUNTER_BITS-1:0] c,
        input logic                    up
    );
        if (up) begin
            return (c == CNT_MAX) ? c : c + COUNTER_BITS'(1);
        end
        return (c == '0) ? c : c - COUNTER_BITS'(1);
    endfunction

    // Saturating increment of a statistics counter.
    function automatic logic [STAT_BITS-1:0] stat_inc(input logic [STAT_BITS-1:0] v);
        return (v == STAT_MAX) ? v : v + STAT_BITS'(1);
    endfunction

    logic [COUNTER_BITS-1:0] pht_q [DEPTH];

    logic [1:0]           actionOut_q,   actionOut_d;
    logic                 mispredict_q,  mispredict_d;
    logic [STAT_BITS-1:0] branchCount_q, branchCount_d;
    logic [STAT_BITS-1:0] missCount_q,   missCount_d;
    logic [COUNTER_BITS-1:0] ctr_d;

    logic [INDEX_BITS-1:0] lookupIdx;
    logic [INDEX_BITS-1:0] resolveIdx;
    logic                  taken;
    logic                  condBranch;
    logic [1:0]            resolvedAction;

    // Upper PC bits and the byte offset do not take part in indexing.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{lookupPc[PC_BITS-1:INDEX_BITS+2], lookupPc[1:0],
                              resolvePc[PC_BITS-1:INDEX_BITS+2], resolvePc[1:0]};

    assign lookupIdx  = lookupPc[INDEX_BITS+1:2];
    assign resolveIdx = resolvePc[INDEX_BITS+1:2];

    // Prediction reads registered table state, so same-cycle training is not visible yet.
    assign lookupTaken = pht_q[lookupIdx][COUNTER_BITS-1];

    // Condition evaluation over the ALU zero/sign flags.
    always_comb begin
        taken = 1'b0;
        case (cond_e'(condition))
            COND_NONE: taken = 1'b1;
            COND_EQ:   taken = statusZero;
            COND_NE:   taken = !statusZero;
            COND_LTZ:  taken = statusNegative;
            COND_GEZ:  taken = !statusNegative;
            COND_LEZ:  taken = statusNegative | statusZero;
            COND_GTZ:  taken = !statusNegative & !statusZero;
            default:   taken = 1'b0;
        endcase
    end

    // Action resolution, training value and statistics next-state.
    always_comb begin
        resolvedAction = actionIn;
        if (actionIn == ACT_BRANCH && !taken) begin
            resolvedAction = ACT_INC;
        end

        condBranch = resolveValid && (actionIn == ACT_BRANCH) && (condition != COND_NONE);

        actionOut_d   = resolveValid ? resolvedAction : ACT_INC;
        mispredict_d  = condBranch && (taken != predictedTaken);
        ctr_d         = ctr_step(pht_q[resolveIdx], taken);
        branchCount_d = branchCount_q;
        missCount_d   = missCount_q;
        if (condBranch) begin
            branchCount_d = stat_inc(branchCount_q);
            if (mispredict_d) begin
                missCount_d = stat_inc(missCount_q);
            end
        end
    end

    // Output/statistics registers; reset discards any resolve in the same cycle.
    always_ff @(posedge clock) begin
        if (!reset) begin
            actionOut_q   <= ACT_INC;
            mispredict_q  <= 1'b0;
            branchCount_q <= '0;
            missCount_q   <= '0;
        end else begin
            actionOut_q   <= actionOut_d;
            mispredict_q  <= mispredict_d;
            branchCount_q <= branchCount_d;
            missCount_q   <= missCount_d;
        end
    end

    // Pattern history table: whole-table clear on reset, single-entry training otherwise.
    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                pht_q[i] <= CNT_INIT;
            end
        end else if (condBranch) begin
            pht_q[resolveIdx] <= ctr_d;
        end
    end

    assign actionOut   = actionOut_q;
    assign mispredict  = mispredict_q;
    assign branchCount = branchCount_q;
    assign missCount   = missCount_q;

endmodule

// File: doc/mips_datapath_pc_predict.md
Name: mips_datapath_pc_predict

Overview:
Parametrised branch resolve-and-predict unit for the pipelined MIPS PC path. It generalises condition resolution from EQ/NE to the full MIPS compare set (EQ, NE, LTZ, GEZ, LEZ, GTZ). It adds a pattern history table of saturating counters that predicts conditional branches at fetch and is trained at execute. Resolved action and mispredict flag are registered for the PC mux and the flush logic, and the block keeps branch and mispredict statistics.

Parameters:
INDEX_BITS, 6, log2 of table depth; index = pc[INDEX_BITS+1:2]
COUNTER_BITS, 2, saturating counter width (≥1)
PC_BITS, 32, program counter width
STAT_BITS, 16, statistics counter width

Ports:
clock  input  1  rising-edge clock
reset  input  1  synchronous, active-low reset
lookupPc  input  PC_BITS  fetch-stage PC
lookupTaken  output  1  prediction: MSB of indexed counter
resolveValid  input  1  execute-stage instruction valid
resolvePc  input  PC_BITS  PC of the resolving instruction
actionIn  input  2  decoded action: 0 Inc, 1 Branch, 2 Jump, 3 JumpReg
condition  input  3  0 None, 1 EQ, 2 NE, 3 LTZ, 4 GEZ, 5 LEZ, 6 GTZ; 7 reserved
statusZero  input  1  ALU result zero
statusNegative  input  1  ALU result sign
predictedTaken  input  1  prediction carried down the pipe with the instruction
actionOut  output  2  registered resolved action
mispredict  output  1  registered one-cycle pulse
branchCount  output  STAT_BITS  resolved conditional branches
missCount  output  STAT_BITS  mispredicted conditional branches

Behaviour:
- Reset (reset==0 at a clock edge): every counter = 2^(COUNTER_BITS-1)-1 (weakly not-taken). actionOut=Inc, mispredict=0, branchCount=missCount=0. The whole table clears in one cycle. An in-flight resolve in that cycle is discarded.
- Lookup: combinational read of registered table state; zero-cycle latency.
- Condition eval (combinational): taken =
  - None: 1
  - EQ: Z
  - NE: !Z
  - LTZ: N
  - GEZ: !N
  - LEZ: N|Z
  - GTZ: !N&!Z
  - reserved: 0
- Resolved action:
  - If actionIn==Branch and !taken, resolve to Inc.
  - Otherwise resolve to actionIn.
  - Jump and JumpReg ignore the condition.
- Conditional branch: resolveValid & actionIn==Branch & condition!=None.
- Registered outputs, 1-cycle latency:
  - actionOut = resolved action if resolveValid, else Inc.
  - mispredict = conditional branch & (taken != predictedTaken).
  - Unconditional Branch (condition None) never sets mispredict and does not train the table.
- Training, on a conditional branch only:
  - Counter at resolvePc index is incremented if taken, decremented if not.
  - Saturates at 0 and at 2^COUNTER_BITS-1.
- Same-cycle lookup and update of the same index: lookupTaken reflects the pre-update value (read-before-write). The update is visible the next cycle.
- Statistics:
  - branchCount += 1 per conditional branch.
  - missCount += 1 when that branch mispredicts.
  - Both saturate at 2^STAT_BITS-1; neither wraps.
- resolveValid==0: no table update, no stat change, actionOut=Inc, mispredict=0.
- PC bits above the index and pc[1:0] are ignored (aliasing is allowed).

Test Plan:
- Reset, then lookupPc=0x40 -> lookupTaken=0. Next cycle: actionOut=0, mispredict=0, both counts 0.
- Branch, condition=EQ, Z=1, predictedTaken=0, pc=0x40 -> next cycle actionOut=1 (Branch), mispredict=1, branchCount=1, missCount=1. Counter 1→2, lookupTaken(0x40)=1 thereafter.
- Sweep all conditions with (Z,N) ∈ {00,01,10} and actionIn=Branch -> actionOut matches the taken table. Condition 7 -> Inc. actionIn=Jump under any condition -> Jump.
- Four taken GTZ branches at pc=0x80 -> counter saturates at 3. One not-taken -> 2, lookupTaken stays 1. pc=0x180 (same index when INDEX_BITS=6) aliases and reads the same counter.
- Lookup and resolve on the same index in the same cycle -> lookupTaken shows the old value, the new value appears the next cycle. Pulse reset low mid-stream -> table and counts return to reset values.
- STAT_BITS=2 build: 5 mispredicting branches -> branchCount=3 and missCount=3 (saturated, no wrap).
